// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
//
// Load/store stage in front of the word-wide data memory port. Takes one
// byte/half/word request from execute, drives the memory port (word-aligned
// address, byte-lane mask, replicated store data) for MEM_LATENCY cycles and
// returns extended load data or a store acknowledge.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. The producer holds valid (and its payload) until that edge. The
// consumer may drive ready at any time without waiting for valid.
//
// Ports
//   clock, reset        : clock; synchronous active-high reset
//   req_valid/req_ready : request handshake (execute -> stage)
//   req_wen, req_addr, req_wdata, req_size, req_unsigned : request payload
//   resp_valid/resp_ready : response handshake (stage -> consumer)
//   resp_rdata, resp_err  : response payload
//   mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask : memory port
//   mem_rdata           : raw word from memory
//
// Build option
//   MISALIGN_TRAP_EN : when defined, misaligned half/word requests skip the
//                      memory and respond with resp_err=1 the cycle after
//                      acceptance. When undefined, resp_err is 0 and low
//                      address bits are ignored for half/word accesses.
//
// The FSM state is held in state_q (type lsu_state_t) for checker binding.
// -----------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_valid,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    lsu_state_t      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            first_q, first_d;

    // Captured request; the req_* inputs are not looked at again until IDLE.
    logic            wen_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [1:0]      size_q;
    logic            uns_q;

    logic [XLEN-1:0] rdata_q;

    logic            take_req;
    logic            access_done;
    logic            req_misaligned;

    // ---------------------------------------------------------------------
    // Misalignment detection on the incoming request
    // ---------------------------------------------------------------------
`ifdef MISALIGN_TRAP_EN
    logic err_q;
    // size 2 and 3 are both words, so size[1] alone identifies a word.
    assign req_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                            (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Store lane steering from the captured request
    // ---------------------------------------------------------------------
    logic [3:0]      st_mask;
    logic [XLEN-1:0] st_data;

    always_comb begin
        st_mask = 4'b1111;
        st_data = wdata_q;
        case (size_q)
            2'd0: begin
                st_mask = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                // addr_q[0] is ignored: halves always land on a half boundary.
                st_mask = 4'b0011 << {addr_q[1], 1'b0};
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Load extraction and extension
    // ---------------------------------------------------------------------
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (size_q)
            2'd0:    ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase

        // Stores acknowledge with zero data.
        if (wen_q) begin
            ld_data = '0;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_valid   = 1'b0;
        take_req    = 1'b0;
        access_done = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    take_req = 1'b1;
                    if (req_misaligned) begin
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = LAT_M1;
                        first_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                mem_valid = 1'b1;
                first_d   = 1'b0;
                if (cnt_q == 4'd0) begin
                    access_done = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Memory port: everything is zero outside ACCESS. Write enable is held
    // only for the first ACCESS cycle so a store is written exactly once.
    // ---------------------------------------------------------------------
    assign mem_wen   = mem_valid & first_q & wen_q;
    assign mem_addr  = mem_valid ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_wmask = (mem_valid && wen_q) ? st_mask : 4'b0000;
    assign mem_wdata = (mem_valid && wen_q) ? st_data : '0;

    assign resp_rdata = resp_valid ? rdata_q : '0;
`ifdef MISALIGN_TRAP_EN
    assign resp_err = resp_valid & err_q;
`else
    assign resp_err = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            first_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            if (take_req) begin
                wen_q   <= req_wen;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
                err_q   <= req_misaligned;
`endif
            end
            if (access_done) begin
                rdata_q <= ld_data;
            end
        end
    end

endmodule
